// File: rtl/hwacc_tcdm_mux.sv
// Funnels lane p of N_ACC accelerators onto one shared TCDM lane p with per-lane
// round-robin arbitration, request-hold, 1-cycle response routing and a contention counter.
//
// state | meaning
// IDLE  | arbitrate round-robin from rr_q among eligible requesters
// HOLD  | a request went ungranted; hold_q keeps the lane until handshake or request drop
module hwacc_tcdm_mux #(
  parameter int unsigned N_ACC   = 3,
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_ACC-1:0]                    acc_mask_i,
  input  logic [N_ACC*N_PORTS-1:0]            acc_req_i,
  output logic [N_ACC*N_PORTS-1:0]            acc_gnt_o,
  input  logic [N_ACC*N_PORTS*ADDR_W-1:0]     acc_add_i,
  input  logic [N_ACC*N_PORTS-1:0]            acc_wen_i,
  input  logic [N_ACC*N_PORTS*DATA_W/8-1:0]   acc_be_i,
  input  logic [N_ACC*N_PORTS*DATA_W-1:0]     acc_data_i,
  output logic [N_ACC*N_PORTS-1:0]            acc_r_valid_o,
  output logic [N_ACC*N_PORTS*DATA_W-1:0]     acc_r_data_o,
  output logic [N_PORTS-1:0]                  tcdm_req_o,
  input  logic [N_PORTS-1:0]                  tcdm_gnt_i,
  output logic [N_PORTS*ADDR_W-1:0]           tcdm_add_o,
  output logic [N_PORTS-1:0]                  tcdm_wen_o,
  output logic [N_PORTS*DATA_W/8-1:0]         tcdm_be_o,
  output logic [N_PORTS*DATA_W-1:0]           tcdm_data_o,
  input  logic [N_PORTS-1:0]                  tcdm_r_valid_i,
  input  logic [N_PORTS*DATA_W-1:0]           tcdm_r_data_i,
  input  logic                                cnt_clear_i,
  output logic [CNT_W-1:0]                    conflict_cnt_o,
  output logic                                resp_err_o
);

  localparam int unsigned IDX_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic {IDLE, HOLD} lane_state_e;

  logic [N_PORTS-1:0] lane_conflict;
  logic [N_PORTS-1:0] resp_unexp;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lane
    lane_state_e      state_q;
    logic [IDX_W-1:0] rr_q, hold_q, own_q, winner;
    logic             out_q, win_valid, hs, hold_live;
    logic [N_ACC-1:0] elig, gnt_l;
    int unsigned      scan_idx;
    logic [ADDR_W-1:0] add_l;
    logic              wen_l;
    logic [BE_W-1:0]   be_l;
    logic [DATA_W-1:0] data_l;

    always_comb begin
      elig = '0;
      for (int a = 0; a < N_ACC; a++) begin
        elig[a] = acc_req_i[a*N_PORTS+p] & acc_mask_i[a];
      end
    end

    // a held requester keeps the lane even if masked; dropping its request breaks the hold
    assign hold_live = (state_q == HOLD) & acc_req_i[int'(hold_q)*N_PORTS+p];

    always_comb begin
      winner    = '0;
      win_valid = 1'b0;
      scan_idx  = 0;
      if (hold_live) begin
        winner    = hold_q;
        win_valid = 1'b1;
      end else begin
        // scan downwards so the lowest offset from rr_q is written last and wins
        for (int i = N_ACC-1; i >= 0; i--) begin
          scan_idx = int'(rr_q) + i;
          if (scan_idx >= N_ACC) scan_idx = scan_idx - N_ACC;
          if (elig[scan_idx]) begin
            winner    = IDX_W'(scan_idx);
            win_valid = 1'b1;
          end
        end
      end
      win_valid = win_valid & rst_ni;
    end

    assign hs = win_valid & tcdm_gnt_i[p];

    always_comb begin
      add_l  = '0;
      wen_l  = 1'b0;
      be_l   = '0;
      data_l = '0;
      gnt_l  = '0;
      for (int a = 0; a < N_ACC; a++) begin
        if (win_valid && winner == IDX_W'(a)) begin
          add_l    = acc_add_i[(a*N_PORTS+p)*ADDR_W +: ADDR_W];
          wen_l    = acc_wen_i[a*N_PORTS+p];
          be_l     = acc_be_i[(a*N_PORTS+p)*BE_W +: BE_W];
          data_l   = acc_data_i[(a*N_PORTS+p)*DATA_W +: DATA_W];
          gnt_l[a] = hs;
        end
      end
    end

    assign tcdm_req_o[p]                    = win_valid;
    assign tcdm_add_o[p*ADDR_W +: ADDR_W]   = add_l;
    assign tcdm_wen_o[p]                    = wen_l;
    assign tcdm_be_o[p*BE_W +: BE_W]        = be_l;
    assign tcdm_data_o[p*DATA_W +: DATA_W]  = data_l;

    for (genvar a = 0; a < N_ACC; a++) begin : g_acc
      assign acc_gnt_o[a*N_PORTS+p]     = gnt_l[a];
      assign acc_r_valid_o[a*N_PORTS+p] = out_q & tcdm_r_valid_i[p] & (own_q == IDX_W'(a));
      assign acc_r_data_o[(a*N_PORTS+p)*DATA_W +: DATA_W] =
        rst_ni ? tcdm_r_data_i[p*DATA_W +: DATA_W] : '0;
    end

    assign lane_conflict[p] = (state_q == IDLE) && ($countones(elig) >= 2);
    assign resp_unexp[p]    = tcdm_r_valid_i[p] & ~out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        rr_q    <= '0;
        hold_q  <= '0;
        own_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        out_q <= hs;
        if (hs) begin
          state_q <= IDLE;
          own_q   <= winner;
          rr_q    <= (winner == IDX_W'(N_ACC-1)) ? '0 : winner + IDX_W'(1);
        end else if (win_valid) begin
          state_q <= HOLD;
          hold_q  <= winner;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_o <= '0;
      resp_err_o     <= 1'b0;
    end else begin
      if (|resp_unexp) resp_err_o <= 1'b1;
      if (cnt_clear_i) begin
        conflict_cnt_o <= '0;
      end else if ((|lane_conflict) && !(&conflict_cnt_o)) begin
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hwacc_tcdm_mux.sv
// Directed bench for hwacc_tcdm_mux: arbitration order, hold, mask, response routing,
// unexpected responses, counter saturation/clear and asynchronous reset.
module tb_hwacc_tcdm_mux;
  localparam int NA = 3, NP = 3, AW = 32, DW = 32, CW = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NA-1:0]         acc_mask;
  logic [NA*NP-1:0]      acc_req, acc_gnt, acc_wen, acc_r_valid;
  logic [NA*NP*AW-1:0]   acc_add;
  logic [NA*NP*DW/8-1:0] acc_be;
  logic [NA*NP*DW-1:0]   acc_data, acc_r_data;
  logic [NP-1:0]         tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic [NP*AW-1:0]      tcdm_add;
  logic [NP*DW/8-1:0]    tcdm_be;
  logic [NP*DW-1:0]      tcdm_data, tcdm_r_data;
  logic                  cnt_clear, resp_err;
  logic [CW-1:0]         conflict_cnt;

  hwacc_tcdm_mux #(.N_ACC(NA), .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc_mask_i(acc_mask),
    .acc_req_i(acc_req), .acc_gnt_o(acc_gnt), .acc_add_i(acc_add), .acc_wen_i(acc_wen),
    .acc_be_i(acc_be), .acc_data_i(acc_data), .acc_r_valid_o(acc_r_valid),
    .acc_r_data_o(acc_r_data), .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt),
    .tcdm_add_o(tcdm_add), .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be),
    .tcdm_data_o(tcdm_data), .tcdm_r_valid_i(tcdm_r_valid), .tcdm_r_data_i(tcdm_r_data),
    .cnt_clear_i(cnt_clear), .conflict_cnt_o(conflict_cnt), .resp_err_o(resp_err)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ix(input int a, input int p);
    return a*NP + p;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int a, input int p);
    if (a == 1 && p == 0) return 32'h100;
    return 32'h1000 + 32'(a)*32'h100 + 32'(p)*32'h10;
  endfunction

  function automatic logic [NA*NP-1:0] bit_of(input int a, input int p);
    logic [NA*NP-1:0] v;
    v = '0;
    v[ix(a, p)] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    acc_mask = '1; acc_req = '0; tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;
    cnt_clear = 1'b0;
    for (int a = 0; a < NA; a++) begin
      for (int p = 0; p < NP; p++) begin
        acc_add[ix(a,p)*AW +: AW]     = addr_of(a, p);
        acc_wen[ix(a,p)]              = a[0];
        acc_be[ix(a,p)*4 +: 4]        = 4'(ix(a,p) + 1);
        acc_data[ix(a,p)*DW +: DW]    = 32'hD000_0000 + 32'(ix(a,p));
      end
    end

    // reset state with a request already present
    acc_req[ix(0,0)] = 1'b1; tcdm_gnt = '1;
    settle();
    chk("rst_req", 64'(tcdm_req), 64'h0);
    chk("rst_gnt", 64'(acc_gnt), 64'h0);
    chk("rst_cnt", 64'(conflict_cnt), 64'h0);
    chk("rst_err", 64'(resp_err), 64'h0);
    tick(); tick();
    acc_req = '0; tcdm_gnt = '0;
    rst_ni = 1'b1;
    settle();
    chk("idle_add_zero", 64'(tcdm_add), 64'h0);

    // single requester acc1 lane0
    tick();
    acc_req[ix(1,0)] = 1'b1; tcdm_gnt[0] = 1'b1;
    settle();
    chk("t1_req", 64'(tcdm_req), 64'h1);
    chk("t1_add", 64'(tcdm_add[0 +: AW]), 64'h100);
    chk("t1_wen", 64'(tcdm_wen[0]), 64'h1);
    chk("t1_be", 64'(tcdm_be[0 +: 4]), 64'h4);
    chk("t1_data", 64'(tcdm_data[0 +: DW]), 64'hD000_0003);
    chk("t1_gnt", 64'(acc_gnt), 64'(bit_of(1,0)));
    tick();
    acc_req = '0; tcdm_r_valid[0] = 1'b1; tcdm_r_data[0 +: DW] = 32'hCAFE;
    settle();
    chk("t1_rvalid", 64'(acc_r_valid), 64'(bit_of(1,0)));
    chk("t1_rdata_bcast", 64'(acc_r_data[ix(2,0)*DW +: DW]), 64'hCAFE);
    chk("t1_err", 64'(resp_err), 64'h0);
    // rr_q[0] is now 2: acc2 beats acc0
    tick();
    tcdm_r_valid = '0;
    acc_req[ix(0,0)] = 1'b1; acc_req[ix(2,0)] = 1'b1;
    settle();
    chk("t1_rr2", 64'(acc_gnt), 64'(bit_of(2,0)));
    tick();
    acc_req = '0;
    settle();
    chk("t1_cnt", 64'(conflict_cnt), 64'h1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    settle();
    chk("clr_cnt", 64'(conflict_cnt), 64'h0);

    // fairness on lane0
    acc_req[ix(0,0)] = 1'b1; acc_req[ix(1,0)] = 1'b1; acc_req[ix(2,0)] = 1'b1;
    tcdm_gnt = '1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("fair_gnt", 64'(acc_gnt), 64'(bit_of(k % 3, 0)));
      chk("fair_add", 64'(tcdm_add[0 +: AW]), 64'(addr_of(k % 3, 0)));
      chk("fair_other", 64'(tcdm_req[2:1]), 64'h0);
      chk("fair_cnt", 64'(conflict_cnt), 64'(k));
      tick();
    end
    acc_req = '0;
    settle();
    chk("fair_cnt_end", 64'(conflict_cnt), 64'h6);

    // hold on lane1: move rr_q[1] to 2, then acc2 and acc0 compete with gnt low
    tcdm_gnt = 3'b010;
    acc_req[ix(1,1)] = 1'b1;
    settle();
    chk("hold_pre", 64'(acc_gnt), 64'(bit_of(1,1)));
    tick();
    acc_req = '0; acc_req[ix(0,1)] = 1'b1; acc_req[ix(2,1)] = 1'b1; tcdm_gnt = '0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_add", 64'(tcdm_add[AW +: AW]), 64'(addr_of(2,1)));
      chk("hold_nogrant", 64'(acc_gnt), 64'h0);
      tick();
    end
    tcdm_gnt = 3'b010;
    settle();
    chk("hold_c4", 64'(acc_gnt), 64'(bit_of(2,1)));
    tick();
    settle();
    chk("hold_c5", 64'(acc_gnt), 64'(bit_of(0,1)));
    tick();
    acc_req = '0;
    settle();
    chk("hold_cnt", 64'(conflict_cnt), 64'h8);

    // mask on lane2
    acc_mask = 3'b101; tcdm_gnt = 3'b100;
    acc_req[ix(0,2)] = 1'b1; acc_req[ix(1,2)] = 1'b1; acc_req[ix(2,2)] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("mask_gnt", 64'(acc_gnt), 64'(bit_of((k % 2) * 2, 2)));
      tick();
    end
    acc_req = '0; acc_mask = '1; tcdm_gnt = '0;
    acc_req[ix(2,2)] = 1'b1;
    settle();
    chk("mhold_win", 64'(tcdm_add[2*AW +: AW]), 64'(addr_of(2,2)));
    tick();
    acc_mask = 3'b011; acc_req[ix(0,2)] = 1'b1;
    settle();
    chk("mhold_keep", 64'(tcdm_add[2*AW +: AW]), 64'(addr_of(2,2)));
    chk("mhold_nogrant", 64'(acc_gnt), 64'h0);
    tick();
    tcdm_gnt = 3'b100;
    settle();
    chk("mhold_gnt", 64'(acc_gnt), 64'(bit_of(2,2)));
    tick();
    acc_req = '0; acc_mask = '1; tcdm_gnt = '0;
    settle();
    chk("mask_cnt", 64'(conflict_cnt), 64'hC);

    // back-to-back responses on lane0
    tcdm_gnt = '1;
    acc_req[ix(0,0)] = 1'b1; acc_req[ix(1,0)] = 1'b1;
    settle();
    chk("b2b_g0", 64'(acc_gnt), 64'(bit_of(0,0)));
    tick();
    acc_req[ix(0,0)] = 1'b0; tcdm_r_valid[0] = 1'b1; tcdm_r_data[0 +: DW] = 32'h1111;
    settle();
    chk("b2b_g1", 64'(acc_gnt), 64'(bit_of(1,0)));
    chk("b2b_r0", 64'(acc_r_valid), 64'(bit_of(0,0)));
    tick();
    acc_req = '0; tcdm_r_data[0 +: DW] = 32'h2222;
    settle();
    chk("b2b_r1", 64'(acc_r_valid), 64'(bit_of(1,0)));
    chk("b2b_d1", 64'(acc_r_data[ix(1,0)*DW +: DW]), 64'h2222);
    chk("b2b_noreq", 64'(tcdm_req), 64'h0);
    chk("b2b_err0", 64'(resp_err), 64'h0);
    tick();
    settle();
    chk("spur_drop", 64'(acc_r_valid), 64'h0);
    tick();
    tcdm_r_valid = '0;
    settle();
    chk("spur_err", 64'(resp_err), 64'h1);

    // saturation and clear priority (count is 13 here)
    acc_req[ix(0,0)] = 1'b1; acc_req[ix(1,0)] = 1'b1; acc_req[ix(2,0)] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    settle();
    chk("sat_cnt", 64'(conflict_cnt), 64'hF);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    settle();
    chk("clr_prio", 64'(conflict_cnt), 64'h0);
    tick();
    settle();
    chk("clr_after", 64'(conflict_cnt), 64'h1);

    // asynchronous reset during HOLD with rr_q[0] != 0
    acc_req = '0; tcdm_gnt = 3'b001;
    acc_req[ix(0,0)] = 1'b1;
    tick();
    acc_req = '0; acc_req[ix(1,0)] = 1'b1; tcdm_gnt = '0;
    tick();
    tcdm_gnt = '1; tcdm_r_valid = '1; tcdm_r_data = '1;
    rst_ni = 1'b0;
    settle();
    chk("arst_req", 64'(tcdm_req), 64'h0);
    chk("arst_gnt", 64'(acc_gnt), 64'h0);
    chk("arst_add", 64'(tcdm_add[0 +: AW]), 64'h0);
    chk("arst_rvalid", 64'(acc_r_valid), 64'h0);
    chk("arst_rdata", 64'(acc_r_data[0 +: DW]), 64'h0);
    chk("arst_cnt", 64'(conflict_cnt), 64'h0);
    chk("arst_err", 64'(resp_err), 64'h0);
    tick();
    acc_req = '0; acc_req[ix(0,0)] = 1'b1; acc_req[ix(2,0)] = 1'b1;
    tcdm_r_valid = 3'b010;
    rst_ni = 1'b1;
    settle();
    chk("post_rst_rr", 64'(acc_gnt), 64'(bit_of(0,0)));
    chk("post_rst_rvalid", 64'(acc_r_valid), 64'h0);
    tick();
    tcdm_r_valid = '0; acc_req = '0;
    settle();
    chk("post_rst_err", 64'(resp_err), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
